baud_prescaler: RTL
===================

Name: baud_prescaler

Overview:
Parametrised successor to the fixed ripple clock divider. It generates UART timing from the system clock:
- a programmable oversample tick (ovs_tick);
- a baud tick every OVS oversample ticks (baud_tick);
- a 50%-duty baud-rate slow_clock;
- the oversample phase count, which the RX sampler uses to centre on each bit.

It sits between the system clock and the tx/rx UART engines. The divisor can be reloaded at runtime through a valid/ready handshake, and a reload never corrupts a bit period in flight.

Parameters:
DIV_W, 16, width of divisor and cycle counter
OVS_LOG2, 4, log2 of oversample factor (OVS = 2**OVS_LOG2)
DEFAULT_DIV, 27, divisor after reset (50 MHz / 115200 / 16)
FRAC_W, 4, fractional divisor width (used only with FRAC_DIV_EN)

Ports:
fast_clock  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = run, 0 = idle/clear
div_value  in  DIV_W  new integer divisor
frac_value  in  FRAC_W  new fractional divisor (ignored without FRAC_DIV_EN)
div_valid  in  1  divisor update request
div_ready  out  1  update can be accepted
ovs_tick  out  1  one-cycle pulse per oversample period
baud_tick  out  1  one-cycle pulse per bit period
slow_clock  out  1  baud-rate square wave
ovs_phase  out  OVS_LOG2  current oversample index within the bit
active  out  1  state == RUN

Behaviour:
- One clock (fast_clock); reset is synchronous and active-high (rst).
- Reset values:
  - div_reg = DEFAULT_DIV; frac_reg = 0; pending = 0; cnt = 0; ovs_phase = 0; frac_acc = 0.
  - ovs_tick = baud_tick = slow_clock = active = 0.
  - div_ready = 0 while rst is high, 1 in the first cycle after.
- Effective divisor D = max(div_reg, 1). div_value = 0 is treated as 1.
- All outputs are registered.
- States:
  - IDLE: counters held at 0, ticks 0, slow_clock 0. enable = 1 moves to RUN in the next cycle.
  - RUN:
    - cnt increments each cycle.
    - When cnt == D-1: cnt wraps to 0 and ovs_tick pulses in the following cycle.
    - The first ovs_tick comes D cycles after the first RUN cycle; subsequent ticks are exactly D cycles apart.
    - On each ovs_tick event, ovs_phase increments modulo OVS.
    - The event that wraps ovs_phase from OVS-1 to 0 also pulses baud_tick, coincident with that ovs_tick.
  - enable = 0 in RUN moves to IDLE next cycle; counters are cleared.
- slow_clock = 1 while ovs_phase < OVS/2 in RUN: high OVS/2·D cycles, low OVS/2·D cycles.
- Handshake: a transfer occurs when div_valid && div_ready.
  - In IDLE: div_reg/frac_reg load next cycle; div_ready stays 1.
  - In RUN: values go to a pending register and div_ready drops to 0. They are committed at the next baud boundary (the ovs_phase wrap event), and the new D governs the next bit. div_ready returns to 1 the cycle after the commit.
  - A transfer in the same cycle as a baud boundary commits at the following boundary, not the current one.
  - A pending update when RUN→IDLE (enable drop) commits in the IDLE entry cycle.
- rst mid-operation: all state returns to reset values next edge; pending is discarded.
- No tick is emitted in IDLE or during rst.

Optional Feature:
FRAC_DIV_EN:
- Defined:
  - A FRAC_W-bit frac_acc adds frac_reg at each ovs period end.
  - A carry out makes the next ovs period D+1 cycles.
  - Average period = D + frac_reg/2^FRAC_W.
  - frac_acc clears in IDLE/rst.
  - frac_value is captured with div_value on each transfer.
- Undefined: frac_value is ignored, no accumulator is built, and every period is exactly D.

Test Plan:
- Reset, enable = 1, defaults (DEFAULT_DIV = 27, OVS = 16) -> ovs_tick every 27 cycles; baud_tick every 432; slow_clock high 216 / low 216; div_ready = 1.
- IDLE, load div_value = 4, then enable -> first ovs_tick 4 cycles after RUN entry; baud_tick period 64; ovs_phase 0..15 repeating.
- RUN at D = 4, load div_value = 8 at mid-bit (ovs_phase = 5) -> div_ready = 0 until commit; the bit in flight stays 64 cycles; the next bit is 128 cycles; div_ready = 1 the cycle after commit.
- div_value = 0 -> ovs_tick every cycle; baud_tick every 16 cycles.
- enable dropped at ovs_phase = 9, and separately rst pulsed mid-run -> all outputs 0 next cycle. After rst, div_reg = 27 and the pending update is discarded.
- FRAC_DIV_EN, div_value = 4, frac_value = 8 (FRAC_W = 4) -> ovs periods alternate 4, 5, 4, 5…; baud_tick period 72 cycles. Without the macro, baud_tick period is 64.

Source files
------------

// File: rtl/baud_prescaler.sv
// baud_prescaler: UART timing generator driven from the system clock.
// Produces an oversample tick, a baud tick every OVS oversample ticks, a
// 50%-duty baud-rate square wave and the oversample phase index. The divisor
// can be reloaded at runtime through a valid/ready handshake; reloads made
// while running are held until the next bit boundary so no bit is distorted.
// Optional feature macro: FRAC_DIV_EN adds a fractional divisor accumulator.
module baud_prescaler #(
    parameter int DIV_W       = 16,
    parameter int OVS_LOG2    = 4,
    parameter int DEFAULT_DIV = 27,
    parameter int FRAC_W      = 4
) (
    input  logic                fast_clock,
    input  logic                rst,
    input  logic                enable,
    input  logic [DIV_W-1:0]    div_value,
    input  logic [FRAC_W-1:0]   frac_value,
    input  logic                div_valid,
    output logic                div_ready,
    output logic                ovs_tick,
    output logic                baud_tick,
    output logic                slow_clock,
    output logic [OVS_LOG2-1:0] ovs_phase,
    output logic                active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_stateNext;

    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_pendDiv;
    logic [DIV_W-1:0]    r_cnt;
    logic [OVS_LOG2-1:0] r_phase;
    logic                r_pending;
    logic                r_ready;
    logic                r_ovsTick;
    logic                r_baudTick;
    logic                r_slow;

    logic [DIV_W-1:0]    w_divEff;
    logic [DIV_W:0]      w_lastCnt;
    logic [DIV_W-1:0]    w_cntNext;
    logic [OVS_LOG2-1:0] w_phaseNext;
    logic                w_running;
    logic                w_periodEnd;
    logic                w_boundary;
    logic                w_xfer;
    logic                w_commit;
    logic                w_pendingNext;
    logic                w_extra;

`ifdef FRAC_DIV_EN
    logic [FRAC_W-1:0] r_frac;
    logic [FRAC_W-1:0] r_pendFrac;
    logic [FRAC_W-1:0] r_acc;
    logic              r_extra;
    logic [FRAC_W:0]   w_accSum;

    assign w_accSum = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_extra  = r_extra;

    // Fraction accumulator: each carry stretches the following period by one cycle
    always_ff @(posedge fast_clock) begin
        if (rst) begin
            r_frac     <= '0;
            r_pendFrac <= '0;
            r_acc      <= '0;
            r_extra    <= 1'b0;
        end else begin
            if (w_running) begin
                if (w_periodEnd) begin
                    r_acc   <= w_accSum[FRAC_W-1:0];
                    r_extra <= w_accSum[FRAC_W];
                end
            end else begin
                r_acc   <= '0;
                r_extra <= 1'b0;
            end
            if (w_commit) begin
                r_frac <= r_pendFrac;
            end
            if (w_xfer) begin
                if (w_running) begin
                    r_pendFrac <= frac_value;
                end else begin
                    r_frac <= frac_value;
                end
            end
        end
    end
`else
    logic w_unused;

    assign w_extra  = 1'b0;
    assign w_unused = ^frac_value;
`endif

    // Period terminal count, handshake decisions and next counter values
    always_comb begin
        w_divEff      = (r_div == '0) ? ONE : r_div;
        w_lastCnt     = {1'b0, w_divEff} - {1'b0, ONE} + {{DIV_W{1'b0}}, w_extra};
        w_running     = (r_state == RUN) && enable;
        w_periodEnd   = w_running && ({1'b0, r_cnt} == w_lastCnt);
        w_boundary    = w_periodEnd && (&r_phase);
        w_xfer        = div_valid && r_ready;
        w_commit      = r_pending && (w_boundary || !w_running);
        w_pendingNext = (r_pending && !w_commit) || (w_xfer && w_running);
        w_cntNext     = '0;
        w_phaseNext   = '0;
        if (w_running) begin
            if (w_periodEnd) begin
                w_cntNext   = '0;
                w_phaseNext = r_phase + 1'b1;
            end else begin
                w_cntNext   = r_cnt + 1'b1;
                w_phaseNext = r_phase;
            end
        end
    end

    // Next-state logic: enable alone decides between idling and running
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: if (enable) w_stateNext = RUN;
            RUN:  if (!enable) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge fast_clock) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Counters, registered outputs and the divisor/pending registers
    always_ff @(posedge fast_clock) begin
        if (rst) begin
            r_div      <= DEF_DIV;
            r_pendDiv  <= '0;
            r_pending  <= 1'b0;
            r_ready    <= 1'b0;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_ovsTick  <= 1'b0;
            r_baudTick <= 1'b0;
            r_slow     <= 1'b0;
        end else begin
            r_cnt      <= w_cntNext;
            r_phase    <= w_phaseNext;
            r_ovsTick  <= w_periodEnd;
            r_baudTick <= w_boundary;
            r_slow     <= (w_stateNext == RUN) && !w_phaseNext[OVS_LOG2-1];
            r_pending  <= w_pendingNext;
            r_ready    <= !w_pendingNext;
            if (w_commit) begin
                r_div <= r_pendDiv;
            end
            if (w_xfer) begin
                if (w_running) begin
                    r_pendDiv <= div_value;
                end else begin
                    r_div <= div_value;
                end
            end
        end
    end

    assign div_ready  = r_ready;
    assign ovs_tick   = r_ovsTick;
    assign baud_tick  = r_baudTick;
    assign slow_clock = r_slow;
    assign ovs_phase  = r_phase;
    assign active     = (r_state == RUN);

endmodule
